// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_gen
// Brief  : Dual-mode VGA timing generator with pixel-clock-enable divider,
//          per-mode sync polarity and frame-boundary mode switching.
// Rev    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CW      = 11,
    parameter int PIX_DIV = 1,
    parameter int H0_DISP = 640,
    parameter int H0_FP   = 16,
    parameter int H0_PW   = 96,
    parameter int H0_BP   = 48,
    parameter int V0_DISP = 480,
    parameter int V0_FP   = 10,
    parameter int V0_PW   = 2,
    parameter int V0_BP   = 33,
    parameter int H1_DISP = 640,
    parameter int H1_FP   = 16,
    parameter int H1_PW   = 96,
    parameter int H1_BP   = 48,
    parameter int V1_DISP = 400,
    parameter int V1_FP   = 12,
    parameter int V1_PW   = 2,
    parameter int V1_BP   = 35,
    parameter bit H0_POL  = 1'b0,
    parameter bit V0_POL  = 1'b0,
    parameter bit H1_POL  = 1'b0,
    parameter bit V1_POL  = 1'b1
) (
    input  logic          pixClk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          mode_sel,
    output logic          mode_active,
    output logic          mode_pending,
    output logic          hsync,
    output logic          vsync,
    output logic          video,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start
);

    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [3:0]    c_DIV_LAST = 4'(PIX_DIV - 1);

    // Display end, sync start, sync end (exclusive) and last count per axis/mode
    localparam logic [CW-1:0] c_H0_DE   = CW'(H0_DISP);
    localparam logic [CW-1:0] c_H0_SS   = CW'(H0_DISP + H0_FP);
    localparam logic [CW-1:0] c_H0_SE   = CW'(H0_DISP + H0_FP + H0_PW);
    localparam logic [CW-1:0] c_H0_LAST = CW'(H0_DISP + H0_FP + H0_PW + H0_BP - 1);
    localparam logic [CW-1:0] c_V0_DE   = CW'(V0_DISP);
    localparam logic [CW-1:0] c_V0_SS   = CW'(V0_DISP + V0_FP);
    localparam logic [CW-1:0] c_V0_SE   = CW'(V0_DISP + V0_FP + V0_PW);
    localparam logic [CW-1:0] c_V0_LAST = CW'(V0_DISP + V0_FP + V0_PW + V0_BP - 1);
    localparam logic [CW-1:0] c_H1_DE   = CW'(H1_DISP);
    localparam logic [CW-1:0] c_H1_SS   = CW'(H1_DISP + H1_FP);
    localparam logic [CW-1:0] c_H1_SE   = CW'(H1_DISP + H1_FP + H1_PW);
    localparam logic [CW-1:0] c_H1_LAST = CW'(H1_DISP + H1_FP + H1_PW + H1_BP - 1);
    localparam logic [CW-1:0] c_V1_DE   = CW'(V1_DISP);
    localparam logic [CW-1:0] c_V1_SS   = CW'(V1_DISP + V1_FP);
    localparam logic [CW-1:0] c_V1_SE   = CW'(V1_DISP + V1_FP + V1_PW);
    localparam logic [CW-1:0] c_V1_LAST = CW'(V1_DISP + V1_FP + V1_PW + V1_BP - 1);

    logic [3:0]    r_div;
    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;
    logic          r_mode;
    logic          r_pend;
    logic          r_hs;
    logic          r_vs;
    logic          r_vid;
    logic [CW-1:0] r_px;
    logic [CW-1:0] r_py;
    logic          r_ls;
    logic          r_fs;

    logic [CW-1:0] w_h_de, w_h_ss, w_h_se, w_h_last;
    logic [CW-1:0] w_v_de, w_v_ss, w_v_se, w_v_last;
    logic          w_h_pol, w_v_pol;
    logic          w_tick;
    logic          w_h_end, w_v_end;
    logic          w_mode_nxt;
    logic          w_vid, w_hs_act, w_vs_act;

    assign w_h_de   = r_mode ? c_H1_DE   : c_H0_DE;
    assign w_h_ss   = r_mode ? c_H1_SS   : c_H0_SS;
    assign w_h_se   = r_mode ? c_H1_SE   : c_H0_SE;
    assign w_h_last = r_mode ? c_H1_LAST : c_H0_LAST;
    assign w_v_de   = r_mode ? c_V1_DE   : c_V0_DE;
    assign w_v_ss   = r_mode ? c_V1_SS   : c_V0_SS;
    assign w_v_se   = r_mode ? c_V1_SE   : c_V0_SE;
    assign w_v_last = r_mode ? c_V1_LAST : c_V0_LAST;
    assign w_h_pol  = r_mode ? H1_POL    : H0_POL;
    assign w_v_pol  = r_mode ? V1_POL    : V0_POL;

    assign w_tick   = en && (r_div == c_DIV_LAST);
    assign w_h_end  = (r_hc == w_h_last);
    assign w_v_end  = (r_vc == w_v_last);

    // The requested mode is only adopted on the very last pixel of a frame
    assign w_mode_nxt = (w_tick && w_h_end && w_v_end) ? mode_sel : r_mode;

    assign w_vid    = (r_hc < w_h_de) && (r_vc < w_v_de);
    assign w_hs_act = (r_hc >= w_h_ss) && (r_hc < w_h_se);
    assign w_vs_act = (r_vc >= w_v_ss) && (r_vc < w_v_se);

    always_ff @(posedge pixClk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_hc   <= '0;
            r_vc   <= '0;
            r_mode <= 1'b0;
            r_pend <= 1'b0;
            r_hs   <= ~H0_POL;
            r_vs   <= ~V0_POL;
            r_vid  <= 1'b0;
            r_px   <= '0;
            r_py   <= '0;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
        end else if (en) begin
            r_div  <= w_tick ? 4'd0 : r_div + 4'd1;
            r_mode <= w_mode_nxt;
            r_pend <= (mode_sel != w_mode_nxt);
            r_ls   <= w_tick && (r_hc == '0);
            r_fs   <= w_tick && (r_hc == '0) && (r_vc == '0);
            if (w_tick) begin
                // Outputs reflect the pixel being left, in the mode it belongs to
                r_vid <= w_vid;
                r_px  <= w_vid ? r_hc : '0;
                r_py  <= w_vid ? r_vc : '0;
                r_hs  <= w_hs_act ? w_h_pol : ~w_h_pol;
                r_vs  <= w_vs_act ? w_v_pol : ~w_v_pol;
                if (w_h_end) begin
                    r_hc <= '0;
                    r_vc <= w_v_end ? '0 : r_vc + c_ONE;
                end else begin
                    r_hc <= r_hc + c_ONE;
                end
            end
        end else begin
            r_ls <= 1'b0;
            r_fs <= 1'b0;
        end
    end

    assign mode_active  = r_mode;
    assign mode_pending = r_pend;
    assign hsync        = r_hs;
    assign vsync        = r_vs;
    assign video        = r_vid;
    assign pix_x        = r_px;
    assign pix_y        = r_py;
    assign line_start   = r_ls;
    assign frame_start  = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_timing_gen
// Brief  : Self-checking bench: two reduced-timing instances (PIX_DIV 1 and 4)
//          against a frame-position reference model, plus a default-timing line.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int CW  = 11;
    localparam int H0D = 16, H0F = 2, H0P = 4, H0B = 3;
    localparam int V0D = 10, V0F = 2, V0P = 2, V0B = 3;
    localparam int H1D = 16, H1F = 2, H1P = 4, H1B = 3;
    localparam int V1D = 8,  V1F = 1, V1P = 2, V1B = 2;
    localparam int HT0 = H0D + H0F + H0P + H0B;
    localparam int VT0 = V0D + V0F + V0P + V0B;
    localparam int HT1 = H1D + H1F + H1P + H1B;
    localparam int VT1 = V1D + V1F + V1P + V1B;
    // {mode_active, mode_pending, hsync, vsync, video, pix_x, pix_y, line_start, frame_start}
    localparam logic [28:0] RST_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 11'd0, 11'd0, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic mode_sel = 1'b0;

    logic          ma [2], mp [2], hs [2], vs [2], vid [2], ls [2], fs [2];
    logic [CW-1:0] px [2], py [2];
    logic [28:0]   obs [2];

    logic          d_ma, d_mp, d_hs, d_vs, d_vid, d_ls, d_fs;
    logic [CW-1:0] d_px, d_py;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        vga_timing_gen #(
            .CW(CW), .PIX_DIV((g == 0) ? 1 : 4),
            .H0_DISP(H0D), .H0_FP(H0F), .H0_PW(H0P), .H0_BP(H0B),
            .V0_DISP(V0D), .V0_FP(V0F), .V0_PW(V0P), .V0_BP(V0B),
            .H1_DISP(H1D), .H1_FP(H1F), .H1_PW(H1P), .H1_BP(H1B),
            .V1_DISP(V1D), .V1_FP(V1F), .V1_PW(V1P), .V1_BP(V1B),
            .H0_POL(1'b0), .V0_POL(1'b0), .H1_POL(1'b0), .V1_POL(1'b1)
        ) u_dut (
            .pixClk(clk), .rst_n(rst_n), .en(en), .mode_sel(mode_sel),
            .mode_active(ma[g]), .mode_pending(mp[g]), .hsync(hs[g]), .vsync(vs[g]),
            .video(vid[g]), .pix_x(px[g]), .pix_y(py[g]),
            .line_start(ls[g]), .frame_start(fs[g])
        );
        assign obs[g] = {ma[g], mp[g], hs[g], vs[g], vid[g], px[g], py[g], ls[g], fs[g]};
    end

    vga_timing_gen u_dut_def (
        .pixClk(clk), .rst_n(rst_n), .en(en), .mode_sel(mode_sel),
        .mode_active(d_ma), .mode_pending(d_mp), .hsync(d_hs), .vsync(d_vs),
        .video(d_vid), .pix_x(d_px), .pix_y(d_py),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // Reference model: position kept as a pixel index within the frame
    int          m_div [2];
    int          m_t [2];
    logic        m_mode [2];
    logic [28:0] e_vec [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_div[k] = 0; m_t[k] = 0; m_mode[k] = 1'b0; e_vec[k] = RST_VEC;
        end
    endtask

    task automatic model_step(input int k);
        int d, ht, vt, hd, vd, hss, hse, vss, vse, hc, vc;
        logic hpol, vpol, tick, v;
        d = (k == 0) ? 1 : 4;
        if (!en) begin
            e_vec[k][1:0] = 2'b00;
            return;
        end
        if (m_mode[k] == 1'b0) begin
            ht = HT0; vt = VT0; hd = H0D; vd = V0D; hpol = 1'b0; vpol = 1'b0;
            hss = H0D + H0F; hse = hss + H0P; vss = V0D + V0F; vse = vss + V0P;
        end else begin
            ht = HT1; vt = VT1; hd = H1D; vd = V1D; hpol = 1'b0; vpol = 1'b1;
            hss = H1D + H1F; hse = hss + H1P; vss = V1D + V1F; vse = vss + V1P;
        end
        tick = (m_div[k] == d - 1);
        m_div[k] = tick ? 0 : m_div[k] + 1;
        if (tick) begin
            hc = m_t[k] % ht;
            vc = m_t[k] / ht;
            v = (hc < hd) && (vc < vd);
            e_vec[k][26]    = (hc >= hss && hc < hse) ? hpol : !hpol;
            e_vec[k][25]    = (vc >= vss && vc < vse) ? vpol : !vpol;
            e_vec[k][24]    = v;
            e_vec[k][23:13] = v ? 11'(hc) : 11'd0;
            e_vec[k][12:2]  = v ? 11'(vc) : 11'd0;
            e_vec[k][1]     = (hc == 0);
            e_vec[k][0]     = (hc == 0) && (vc == 0);
            m_t[k]++;
            if (m_t[k] == ht * vt) begin
                m_t[k] = 0;
                m_mode[k] = mode_sel;
            end
        end else begin
            e_vec[k][1:0] = 2'b00;
        end
        e_vec[k][28] = m_mode[k];
        e_vec[k][27] = (mode_sel != m_mode[k]);
    endtask

    always @(negedge rst_n) model_reset();
    always @(posedge clk) if (rst_n) for (int k = 0; k < 2; k++) model_step(k);

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode_sel = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== RST_VEC) begin
                n_fail++; $display("FAIL reset_state k=%0d got=%h exp=%h", k, obs[k], RST_VEC);
            end
        end
        n_cmp++;
        if ({d_hs, d_vs, d_vid, d_ls, d_fs, d_ma} !== 6'b110000) begin
            n_fail++; $display("FAIL reset_default got=%b exp=110000", {d_hs, d_vs, d_vid, d_ls, d_fs, d_ma});
        end
        rst_n = 1'b1; en = 1'b1;
    endtask

    task automatic test_default_line();
        int n_hs, n_vid, n_ls, first_hs;
        n_hs = 0; n_vid = 0; n_ls = 0; first_hs = -1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_dl k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
            if (d_hs == 1'b0) begin
                n_hs++;
                if (first_hs < 0) first_hs = i;
            end
            if (d_vid) n_vid++;
            if (d_ls) n_ls++;
            if (i == 0) begin
                n_cmp++;
                if (d_fs !== 1'b1) begin n_fail++; $display("FAIL def_first_frame_start got=%b exp=1", d_fs); end
            end
            if (i == 639 || i == 640) begin
                n_cmp++;
                if (d_px !== ((i == 639) ? 11'd639 : 11'd0)) begin
                    n_fail++; $display("FAIL def_pix_x_edge i=%0d got=%0d", i, d_px);
                end
            end
        end
        n_cmp++;
        if (n_hs != 96 || first_hs != 656) begin
            n_fail++; $display("FAIL def_hsync got=%0d@%0d exp=96@656", n_hs, first_hs);
        end
        n_cmp++;
        if (n_vid != 640 || n_ls != 1) begin
            n_fail++; $display("FAIL def_video_ls got=%0d/%0d exp=640/1", n_vid, n_ls);
        end
        @(negedge clk);
        n_cmp++;
        if (d_ls !== 1'b1 || d_vs !== 1'b1) begin
            n_fail++; $display("FAIL def_line_period ls=%b vs=%b exp=1/1", d_ls, d_vs);
        end
    endtask

    task automatic test_frame();
        int w, n_vs, max_x, max_y;
        w = 0;
        while (fs[0] !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        n_vs = 0; max_x = 0; max_y = 0;
        for (int i = 1; i <= HT0 * VT0; i++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_frame k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
            if (i < HT0 * VT0 && vs[0] == 1'b0) n_vs++;
            if (int'(px[0]) > max_x) max_x = int'(px[0]);
            if (int'(py[0]) > max_y) max_y = int'(py[0]);
        end
        n_cmp++;
        if (fs[0] !== 1'b1) begin n_fail++; $display("FAIL frame_period got=%b exp=1", fs[0]); end
        n_cmp++;
        if (n_vs != V0P * HT0 || max_x != H0D - 1 || max_y != V0D - 1) begin
            n_fail++; $display("FAIL frame_bounds vs=%0d x=%0d y=%0d exp=%0d/%0d/%0d", n_vs, max_x, max_y,
                               V0P * HT0, H0D - 1, V0D - 1);
        end
    endtask

    task automatic test_mode_switch();
        int w, len, n_vs;
        repeat (5 * HT0) @(negedge clk);
        mode_sel = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (mp[0] !== 1'b1 || ma[0] !== 1'b0) begin
            n_fail++; $display("FAIL mode_pending got=%b%b exp=10", mp[0], ma[0]);
        end
        w = 0;
        while (fs[0] !== 1'b1 && w < 1000) begin
            @(negedge clk); w++;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_ms k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
        end
        n_cmp++;
        if (ma[0] !== 1'b1 || mp[0] !== 1'b0) begin
            n_fail++; $display("FAIL mode_latch got=%b%b exp=10", ma[0], mp[0]);
        end
        len = 0; n_vs = 0;
        do begin
            @(negedge clk); len++;
            if (vs[0] == 1'b1) n_vs++;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_m1 k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
        end while (fs[0] !== 1'b1 && len < 1000);
        n_cmp++;
        if (len != HT1 * VT1 || n_vs != V1P * HT1) begin
            n_fail++; $display("FAIL mode1_frame len=%0d vs=%0d exp=%0d/%0d", len, n_vs, HT1 * VT1, V1P * HT1);
        end
    endtask

    task automatic test_pix_div();
        int w, len;
        logic second;
        w = 0;
        while (ls[1] !== 1'b1 && w < 200) begin @(negedge clk); w++; end
        len = 0; second = 1'b0;
        do begin
            @(negedge clk); len++;
            if (len == 1) second = ls[1];
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_div k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
        end while (ls[1] !== 1'b1 && len < 500);
        n_cmp++;
        if (len != 4 * HT0 || second !== 1'b0) begin
            n_fail++; $display("FAIL div4_line len=%0d width2=%b exp=%0d/0", len, second, 4 * HT0);
        end
    endtask

    task automatic test_enable();
        int w;
        logic [28:0] held;
        w = 0;
        while (!(vid[0] === 1'b1 && px[0] == 11'd5) && w < 2000) begin @(negedge clk); w++; end
        held = obs[0];
        en = 1'b0;
        repeat (50) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_en k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
        end
        n_cmp++;
        if (obs[0] !== {held[28:2], 2'b00}) begin
            n_fail++; $display("FAIL en_freeze got=%h exp=%h", obs[0], {held[28:2], 2'b00});
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (px[0] !== 11'd6) begin n_fail++; $display("FAIL en_resume got=%0d exp=6", px[0]); end
        repeat (100) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_res k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        repeat (4000) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_rand k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 199) == 0) mode_sel = ~mode_sel;
        end
        en = 1'b1;
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== RST_VEC) begin
                n_fail++; $display("FAIL async_reset k=%0d got=%h exp=%h", k, obs[k], RST_VEC);
            end
        end
        n_cmp++;
        if (d_hs !== 1'b1 || d_vs !== 1'b1) begin
            n_fail++; $display("FAIL async_reset_def got=%b%b exp=11", d_hs, d_vs);
        end
        mode_sel = 1'b0; en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fs[0] !== 1'b1 || ma[0] !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_fs got=%b%b exp=10", fs[0], ma[0]);
        end
        repeat (600) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs[k] !== e_vec[k]) begin
                    n_fail++; $display("FAIL model_pr k=%0d t=%0t got=%h exp=%h", k, $time, obs[k], e_vec[k]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_line();
        test_frame();
        test_mode_switch();
        test_pix_div();
        test_enable();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
